// File: rtl/fifo_wr_ctrl.sv
// Write-side controller of an asynchronous FIFO: binary/Gray write pointer,
// full / almost-full / level flags against the synchronized read pointer, sticky overflow.
module fifo_wr_ctrl #(
    parameter int ADDR_WIDTH = 3,
    parameter int AF_THRESH  = 6
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    output logic                  wr_mem_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [ADDR_WIDTH:0]   wr_ptr_gray,
    input  logic [ADDR_WIDTH:0]   rd_ptr_gray_sync,
    output logic                  full,
    output logic                  almost_full,
    output logic [ADDR_WIDTH:0]   wr_level,
    output logic                  overflow,
    input  logic                  ovf_clr
);

    localparam int AW = ADDR_WIDTH;
    localparam int PW = ADDR_WIDTH + 1;
    localparam logic [AW:0] AF_T = PW'(AF_THRESH);

    function automatic logic [AW:0] bin2gray(input logic [AW:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [AW:0] gray2bin(input logic [AW:0] g);
        logic [AW:0] b;
        b[AW] = g[AW];
        for (int i = AW - 1; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [AW:0] wbin;
    logic [AW:0] wbin_next;
    logic [AW:0] wgray_next;
    logic [AW:0] rbin;
    logic [AW:0] level_next;
    logic        full_next;
    logic        af_next;
    logic        ovf_next;
    logic        push;

    // Accept path: everything the memory sees is combinational from registered state.
    assign push      = wr_valid & ~full;
    assign wr_mem_en = push;
    assign wr_ready  = ~full;
    assign wr_addr   = wbin[AW-1:0];

    // Next-state pointers and flags, computed from the post-write pointer and the
    // current synchronized read pointer so simultaneous write/read are both seen.
    always_comb begin
        wbin_next  = wbin + {{AW{1'b0}}, push};
        wgray_next = bin2gray(wbin_next);
        rbin       = gray2bin(rd_ptr_gray_sync);
        level_next = wbin_next - rbin;
        full_next  = (wgray_next == {~rd_ptr_gray_sync[AW:AW-1], rd_ptr_gray_sync[AW-2:0]});
        af_next    = (level_next >= AF_T);
        ovf_next   = (wr_valid & full) | (overflow & ~ovf_clr);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wbin        <= '0;
            wr_ptr_gray <= '0;
            full        <= 1'b0;
            almost_full <= 1'b0;
            wr_level    <= '0;
            overflow    <= 1'b0;
        end else begin
            wbin        <= wbin_next;
            wr_ptr_gray <= wgray_next;
            full        <= full_next;
            almost_full <= af_next;
            wr_level    <= level_next;
            overflow    <= ovf_next;
        end
    end

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Scoreboard bench for fifo_wr_ctrl: a counting FIFO model predicts each cycle,
// a monitor process pops and compares DUT outputs.
`timescale 1ns/100ps
module tb_fifo_wr_ctrl;

    logic       clk = 1'b0;
    logic       resetn;
    logic       wr_valid;
    logic       wr_ready;
    logic       wr_mem_en;
    logic [2:0] wr_addr;
    logic [3:0] wr_ptr_gray;
    logic [3:0] rd_ptr_gray_sync;
    logic       full;
    logic       almost_full;
    logic [3:0] wr_level;
    logic       overflow;
    logic       ovf_clr;

    fifo_wr_ctrl #(.ADDR_WIDTH(3), .AF_THRESH(6)) dut (
        .clk(clk), .resetn(resetn), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_mem_en(wr_mem_en), .wr_addr(wr_addr), .wr_ptr_gray(wr_ptr_gray),
        .rd_ptr_gray_sync(rd_ptr_gray_sync), .full(full), .almost_full(almost_full),
        .wr_level(wr_level), .overflow(overflow), .ovf_clr(ovf_clr)
    );

    always #10 clk = ~clk;

    typedef struct {
        logic       en;
        logic [2:0] addr;
        logic       ready;
        logic [3:0] gray;
        logic       full;
        logic       af;
        logic [3:0] level;
        logic       ovf;
    } txn_t;

    txn_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model: total words written and total words read as plain integers.
    int   m_w = 0;
    int   m_r = 0;
    bit   m_full = 0;
    bit   m_ovf  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] gray_of(input int x);
        logic [3:0] b;
        b = 4'(x % 16);
        return b ^ (b >> 1);
    endfunction

    // One stimulus cycle: drive at negedge, predict, push expectation.
    task automatic drive(input bit v, input int r, input bit clr);
        txn_t t;
        int   lvl;
        @(negedge clk);
        wr_valid         = v;
        rd_ptr_gray_sync = gray_of(r);
        ovf_clr          = clr;
        t.en    = v && !m_full;
        t.addr  = 3'(m_w % 8);
        t.ready = !m_full;
        t.ovf   = (v && m_full) || (m_ovf && !clr);
        if (t.en) m_w++;
        m_r    = r;
        lvl    = m_w - m_r;
        m_full = (lvl == 8);
        m_ovf  = t.ovf;
        t.full  = m_full;
        t.af    = (lvl >= 6);
        t.level = 4'(lvl);
        t.gray  = gray_of(m_w);
        q.push_back(t);
    endtask

    // Monitor: combinational outputs just after inputs settle, registered ones after the edge.
    initial begin
        logic       s_en, s_ready;
        logic [2:0] s_addr;
        txn_t       t;
        forever begin
            @(negedge clk);
            #2;
            s_en = wr_mem_en; s_ready = wr_ready; s_addr = wr_addr;
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                t = q.pop_front();
                chk("wr_mem_en",   32'(s_en),        32'(t.en));
                chk("wr_ready",    32'(s_ready),     32'(t.ready));
                if (t.en) chk("wr_addr", 32'(s_addr), 32'(t.addr));
                chk("wr_ptr_gray", 32'(wr_ptr_gray), 32'(t.gray));
                chk("full",        32'(full),        32'(t.full));
                chk("almost_full", 32'(almost_full), 32'(t.af));
                chk("wr_level",    32'(wr_level),    32'(t.level));
                chk("overflow",    32'(overflow),    32'(t.ovf));
            end
        end
    end

    task automatic chk_reset_state(input string tag);
        chk({tag, "_ready"}, 32'(wr_ready),    32'd1);
        chk({tag, "_addr"},  32'(wr_addr),     32'd0);
        chk({tag, "_gray"},  32'(wr_ptr_gray), 32'd0);
        chk({tag, "_full"},  32'(full),        32'd0);
        chk({tag, "_af"},    32'(almost_full), 32'd0);
        chk({tag, "_level"}, 32'(wr_level),    32'd0);
        chk({tag, "_ovf"},   32'(overflow),    32'd0);
        chk({tag, "_men"},   32'(wr_mem_en),   32'd0);
    endtask

    initial begin
        int r;
        int guard;
        resetn = 1'b1; wr_valid = 1'b0; ovf_clr = 1'b0; rd_ptr_gray_sync = '0;
        #2 resetn = 1'b0;
        #1 chk_reset_state("rst_async");
        // Writes during reset must be ignored.
        wr_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_hold_addr", 32'(wr_addr),     32'd0);
        chk("rst_hold_gray", 32'(wr_ptr_gray), 32'd0);
        @(negedge clk);
        wr_valid = 1'b0;
        resetn   = 1'b1;

        // Fill with read pointer at zero.
        for (int i = 0; i < 8; i++) drive(1, 0, 0);
        @(posedge clk); #1;
        chk("fill_gray",  32'(wr_ptr_gray), 32'hc);
        chk("fill_full",  32'(full),        32'd1);
        chk("fill_level", 32'(wr_level),    32'd8);

        // Overflow set, set-beats-clear, then clear.
        drive(1, 0, 0);
        drive(1, 0, 1);
        drive(0, 0, 1);

        // Drain three words.
        drive(0, 3, 0);
        @(posedge clk); #1;
        chk("drain_level", 32'(wr_level), 32'd5);
        chk("drain_full",  32'(full),     32'd0);

        // Wrap with the reader trailing by two.
        drive(0, m_w - 2, 0);
        for (int i = 0; i < 16; i++) drive(1, m_w - 1, 0);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            r = m_r;
            if ($urandom_range(0, 1) == 1) r = m_r + int'($urandom_range(0, m_w - m_r));
            drive($urandom_range(0, 3) != 0, r, $urandom_range(0, 7) == 0);
        end

        // Mid-operation reset from full with overflow set.
        guard = 0;
        while (!m_full && guard < 20) begin
            drive(1, m_r, 0);
            guard++;
        end
        drive(1, m_r, 0);
        @(posedge clk); #1;
        chk("pre_rst_full", 32'(full),     32'd1);
        chk("pre_rst_ovf",  32'(overflow), 32'd1);
        #1;
        wr_valid = 1'b0; rd_ptr_gray_sync = '0;
        resetn = 1'b0;
        #1 chk_reset_state("rst_mid");
        #2 resetn = 1'b1;
        m_w = 0; m_r = 0; m_full = 0; m_ovf = 0;
        drive(1, 0, 0);
        for (int i = 0; i < 20; i++) begin
            r = m_r;
            if ($urandom_range(0, 1) == 1) r = m_r + int'($urandom_range(0, m_w - m_r));
            drive($urandom_range(0, 1) == 1, r, 0);
        end

        @(posedge clk); #3;
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
